// File: rtl/oscillator_if.sv
// Oscillator control bus: per-tick controls in, registered signed sample out.
// Each envelope entry packs {rate[15:0] as Q8.8 gain, duration[23:0] in samples}.
interface oscillator_if #(
  parameter int WIDTH = 24
);
  logic                    enable;
  logic [7:0]              cmds;
  logic [15:0]             freq;
  logic [7:0][39:0]        envelopes;
  logic [23:0]             amplitude;
  logic [1:0]              shape;
  logic signed [WIDTH-1:0] out;

  modport master (
    output enable, cmds, freq, envelopes, amplitude, shape,
    input  out
  );

  modport slave (
    input  enable, cmds, freq, envelopes, amplitude, shape,
    output out
  );
endinterface

// File: rtl/oscillator.sv
// Phase-accumulator oscillator (saw/square/triangle/sine) shaped by an 8-stage
// gain envelope; state advances only on enable ticks, output saturates to WIDTH.
module oscillator #(
  parameter int WIDTH = 24
) (
  input logic         clk,
  input logic         rst,
  oscillator_if.slave bus
);

  localparam int                    ENVELOPE_RESET_BIT = 0;
  localparam logic [31:0]           STEP_SCALE         = 32'd89478;
  localparam logic [1:0]            SHAPE_SAW          = 2'd0;
  localparam logic [1:0]            SHAPE_SQUARE       = 2'd1;
  localparam logic [1:0]            SHAPE_TRIANGLE     = 2'd2;
  localparam logic [1:0]            SHAPE_SIN          = 2'd3;
  localparam int                    EXT                = (WIDTH > 35) ? WIDTH : 35;
  localparam logic signed [EXT-1:0] SAT_MAX = {{(EXT - WIDTH + 1){1'b0}}, {(WIDTH - 1){1'b1}}};
  localparam logic signed [EXT-1:0] SAT_MIN = ~SAT_MAX;
  localparam logic signed [127:0]   PI_Q60  = 128'sh3243F6A8885A308D;

  typedef enum logic {ENV_RUN, ENV_DONE} env_state_t;

  // Quarter-wave sine, round(32767*sin(pi/2*j/256)), evaluated at elaboration
  // with a Q60 Taylor series; the other quadrants come from symmetry.
  function automatic logic signed [15:0] quarter_sin(input int j);
    logic signed [127:0] x, term, acc;
    x    = (PI_Q60 * 128'(j)) / 128'sd512;
    term = x;
    acc  = '0;
    for (int n = 1; n < 24; n += 2) begin
      acc  = acc + term;
      term = -((((term * x) >>> 60) * x) >>> 60) / 128'((n + 1) * (n + 2));
    end
    return 16'((acc * 128'sd32767 + (128'sd1 <<< 59)) >>> 60);
  endfunction

  logic signed [15:0] quarter [257];

  for (genvar j = 0; j < 257; j++) begin : g_quarter
    localparam logic signed [15:0] VALUE = quarter_sin(j);
    assign quarter[j] = VALUE;
  end

  logic [31:0]             phase, cur_phase, next_phase, step;
  logic [2:0]              stage, cur_stage, next_stage;
  logic [23:0]             count, cur_count, next_count, duration, last_count;
  env_state_t              env_state, cur_env_state, next_env_state;
  logic                    restart, unused_cmds;
  logic [15:0]             upper, gain;
  logic [8:0]              sin_index;
  logic signed [15:0]      sin_mag, wave;
  logic signed [40:0]      prod1;
  logic signed [25:0]      s1;
  logic signed [42:0]      prod2;
  logic signed [34:0]      s2;
  logic signed [EXT-1:0]   s2_ext;
  logic signed [WIDTH-1:0] sample, out_q;

  assign unused_cmds = ^bus.cmds[7:1];
  assign step        = {16'd0, bus.freq} * STEP_SCALE;
  assign upper       = cur_phase[31:16];
  assign sin_index   = cur_phase[30] ? (9'd256 - {1'b0, cur_phase[29:22]}) : {1'b0, cur_phase[29:22]};
  assign sin_mag     = quarter[sin_index];

  // A restart makes this tick see a cleared phase/envelope before sampling.
  always_comb begin
    restart       = bus.cmds[ENVELOPE_RESET_BIT];
    cur_phase     = restart ? 32'd0 : phase;
    cur_stage     = restart ? 3'd0 : stage;
    cur_count     = restart ? 24'd0 : count;
    cur_env_state = restart ? ENV_RUN : env_state;
  end

  always_comb begin
    wave = '0;
    case (bus.shape)
      SHAPE_SAW:      wave = $signed(upper ^ 16'h8000);
      SHAPE_SQUARE:   wave = cur_phase[31] ? -16'sd32767 : 16'sd32767;
      SHAPE_TRIANGLE: wave = upper[15] ? $signed(16'h7FFF - {upper[14:0], 1'b0})
                                       : $signed({upper[14:0], 1'b0} ^ 16'h8000);
      SHAPE_SIN:      wave = cur_phase[31] ? -sin_mag : sin_mag;
      default:        wave = '0;
    endcase

    gain   = (cur_env_state == ENV_DONE) ? 16'd0 : bus.envelopes[cur_stage][39:24];
    prod1  = 41'(wave) * 41'($signed({1'b0, bus.amplitude}));
    s1     = 26'(prod1 >>> 15);
    prod2  = 43'(s1) * 43'($signed({1'b0, gain}));
    s2     = 35'(prod2 >>> 8);
    s2_ext = EXT'(s2);

    if (s2_ext > SAT_MAX)      sample = SAT_MAX[WIDTH-1:0];
    else if (s2_ext < SAT_MIN) sample = SAT_MIN[WIDTH-1:0];
    else                       sample = s2_ext[WIDTH-1:0];
  end

  // Duration 0 is treated as a one-sample stage; leaving stage 7 parks in DONE.
  always_comb begin
    duration       = bus.envelopes[cur_stage][23:0];
    last_count     = (duration == 24'd0) ? 24'd0 : duration - 24'd1;
    next_phase     = cur_phase + step;
    next_stage     = cur_stage;
    next_count     = cur_count;
    next_env_state = cur_env_state;
    if (cur_env_state == ENV_RUN) begin
      if (cur_count >= last_count) begin
        next_count = 24'd0;
        if (cur_stage == 3'd7) next_env_state = ENV_DONE;
        else                   next_stage     = cur_stage + 3'd1;
      end else begin
        next_count = cur_count + 24'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase     <= '0;
      stage     <= '0;
      count     <= '0;
      env_state <= ENV_RUN;
      out_q     <= '0;
    end else if (bus.enable) begin
      phase     <= next_phase;
      stage     <= next_stage;
      count     <= next_count;
      env_state <= next_env_state;
      out_q     <= sample;
    end
  end

  assign bus.out = out_q;

endmodule

// File: tb/tb_oscillator.sv
// Self-checking bench for oscillator: constant vector table, hand-written
// envelope/freeze/reset sequences, and randomized ticks against a sample-level model.
module tb_oscillator;

  localparam int     WIDTH  = 24;
  localparam longint SAT_HI = (longint'(1) << (WIDTH - 1)) - 1;
  localparam longint SAT_LO = -(longint'(1) << (WIDTH - 1));

  typedef struct {
    logic [1:0]  shape;
    logic [15:0] freq;
    logic [23:0] amp;
    logic [7:0]  cmd;
    int          expected;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  cfg_shape;
  logic [15:0] cfg_freq;
  logic [23:0] cfg_amp;
  logic [15:0] env_rate [8];
  logic [23:0] env_dur  [8];

  int     checks   = 0;
  int     failures = 0;
  int     sin_table [1024];
  longint m_phase, m_count, m_out;
  int     m_stage;
  vec_t   vecs [$];
  int     exp_env   [14] = '{255, 255, 255, 127, 127, 0, 0, 0, 0, 0, 0, 0, 0, 0};
  int     exp_phase [6]  = '{199, 199, 199, -200, -200, 199};

  oscillator_if #(.WIDTH(WIDTH)) bus ();

  oscillator #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  assign bus.shape     = cfg_shape;
  assign bus.freq      = cfg_freq;
  assign bus.amplitude = cfg_amp;

  always_comb begin
    for (int i = 0; i < 8; i++) bus.envelopes[i] = {env_rate[i], env_dur[i]};
  end

  task automatic check_output(input string name, input logic signed [63:0] actual, input longint expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: out=%0d expected=%0d", name, actual, expected);
    end
  endtask

  function automatic longint model_wave(input logic [1:0] shp, input longint p);
    longint u;
    u = p >> 16;
    case (shp)
      2'd0:    return u - 32768;
      2'd1:    return (p < 64'sd2147483648) ? 64'sd32767 : -64'sd32767;
      2'd2:    return (u < 32768) ? 2 * u - 32768 : 32767 - 2 * (u - 32768);
      default: return longint'(sin_table[p >> 22]);
    endcase
  endfunction

  task automatic model_reset();
    m_phase = 0;
    m_stage = 0;
    m_count = 0;
    m_out   = 0;
  endtask

  // One audio sample: sample from the current state, then advance phase and
  // spend one sample of the current stage (stage 8 stands for DONE).
  task automatic model_tick(input logic [7:0] c);
    longint w, g, s1, s2, dur;
    if (c[0]) begin
      m_phase = 0;
      m_stage = 0;
      m_count = 0;
    end
    w     = model_wave(cfg_shape, m_phase);
    g     = (m_stage > 7) ? 0 : longint'(env_rate[m_stage]);
    s1    = (w * longint'(cfg_amp)) >>> 15;
    s2    = (s1 * g) >>> 8;
    m_out = (s2 > SAT_HI) ? SAT_HI : ((s2 < SAT_LO) ? SAT_LO : s2);
    m_phase = (m_phase + longint'(cfg_freq) * 89478) % 64'sd4294967296;
    if (m_stage <= 7) begin
      dur = longint'(env_dur[m_stage]);
      if (dur == 0) dur = 1;
      m_count++;
      if (m_count >= dur) begin
        m_count = 0;
        m_stage++;
      end
    end
  endtask

  task automatic apply_stimulus(input logic [7:0] c);
    bus.cmds   = c;
    bus.enable = 1'b1;
    @(posedge clk);
    #1;
    bus.enable = 1'b0;
    bus.cmds   = 8'd0;
    model_tick(c);
  endtask

  task automatic idle(input int n, input logic [7:0] c);
    bus.cmds = c;
    repeat (n) @(posedge clk);
    #1;
    bus.cmds = 8'd0;
  endtask

  task automatic set_envelopes(input logic [15:0] rate, input logic [23:0] dur);
    for (int i = 0; i < 8; i++) begin
      env_rate[i] = rate;
      env_dur[i]  = dur;
    end
  endtask

  task automatic randomize_config();
    cfg_shape = 2'($urandom_range(0, 3));
    cfg_freq  = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'($urandom_range(0, 2000));
    cfg_amp   = ($urandom_range(0, 3) == 0) ? 24'($urandom) : 24'($urandom_range(0, 70000));
    for (int i = 0; i < 8; i++) begin
      env_rate[i] = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 512));
      env_dur[i]  = 24'($urandom_range(0, 4));
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, failures=%0d", failures);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] c;
    int         gap;
    real        r;

    for (int k = 0; k < 1024; k++) begin
      r = 32767.0 * $sin(2.0 * 3.14159265358979323846 * k / 1024.0);
      sin_table[k] = (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(0.5 - r);
    end

    rst        = 1'b1;
    bus.enable = 1'b0;
    bus.cmds   = 8'd0;
    cfg_shape  = 2'd1;
    cfg_freq   = 16'd12000;
    cfg_amp    = 24'd200;
    set_envelopes(16'd256, 24'd1000);
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    check_output("reset_hold", 64'(bus.out), 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_output("reset_release_idle", 64'(bus.out), 0);

    // First entries run straight out of reset, so phase starts at 0 without a restart.
    vecs.push_back('{2'd1, 16'd12000, 24'd200, 8'd0,  199});
    vecs.push_back('{2'd1, 16'd12000, 24'd200, 8'd0,  199});
    vecs.push_back('{2'd1, 16'd12000, 24'd200, 8'd0,  199});
    vecs.push_back('{2'd1, 16'd12000, 24'd200, 8'd0, -200});
    vecs.push_back('{2'd1, 16'd12000, 24'd200, 8'd0, -200});
    vecs.push_back('{2'd1, 16'd12000, 24'd200, 8'd0,  199});
    vecs.push_back('{2'd1, 16'd12000, 24'd200, 8'd0,  199});
    vecs.push_back('{2'd1, 16'd12000, 24'd200, 8'd0, -200});
    vecs.push_back('{2'd1, 16'd12000, 24'd200, 8'd0, -200});
    vecs.push_back('{2'd0, 16'd0,     24'd256, 8'd1, -256});
    vecs.push_back('{2'd0, 16'd0,     24'd256, 8'd0, -256});
    vecs.push_back('{2'd0, 16'd0,     24'd256, 8'd0, -256});
    vecs.push_back('{2'd3, 16'd0,     24'd256, 8'd1,    0});
    vecs.push_back('{2'd3, 16'd0,     24'd256, 8'd0,    0});
    vecs.push_back('{2'd2, 16'd0,     24'd256, 8'd1, -256});
    vecs.push_back('{2'd1, 16'd0,     24'd256, 8'd1,  255});

    foreach (vecs[i]) begin
      cfg_shape = vecs[i].shape;
      cfg_freq  = vecs[i].freq;
      cfg_amp   = vecs[i].amp;
      apply_stimulus(vecs[i].cmd);
      check_output($sformatf("vec%0d", i), 64'(bus.out), longint'(vecs[i].expected));
    end

    cfg_shape = 2'd1;
    cfg_freq  = 16'd0;
    cfg_amp   = 24'd256;
    set_envelopes(16'd0, 24'd1);
    env_rate[0] = 16'd256;
    env_dur[0]  = 24'd3;
    env_rate[1] = 16'd128;
    env_dur[1]  = 24'd2;
    for (int i = 0; i < 14; i++) begin
      apply_stimulus((i == 0) ? 8'd1 : 8'd0);
      check_output($sformatf("env_seq%0d", i), 64'(bus.out), longint'(exp_env[i]));
    end

    // Restart from DONE, with a long enable-low gap inside stage 1.
    for (int i = 0; i < 14; i++) begin
      if (i == 4) begin
        idle(100, 8'd1);
        check_output("env_freeze", 64'(bus.out), 127);
      end
      apply_stimulus((i == 0) ? 8'd1 : 8'd0);
      check_output($sformatf("env_restart%0d", i), 64'(bus.out), longint'(exp_env[i]));
    end

    cfg_freq = 16'd12000;
    cfg_amp  = 24'd200;
    set_envelopes(16'd256, 24'd1000);
    for (int i = 0; i < 6; i++) begin
      if (i == 2) begin
        idle(100, 8'hFF);
        check_output("phase_freeze", 64'(bus.out), 199);
      end
      apply_stimulus((i == 0) ? 8'd1 : 8'd0);
      check_output($sformatf("phase_seq%0d", i), 64'(bus.out), longint'(exp_phase[i]));
    end

    #3;
    rst = 1'b1;
    #1;
    check_output("reset_async", 64'(bus.out), 0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check_output("reset_idle", 64'(bus.out), 0);
    apply_stimulus(8'd0);
    check_output("reset_first_tick", 64'(bus.out), 199);

    for (int t = 0; t < 400; t++) begin
      if (t % 25 == 0) randomize_config();
      c    = 8'($urandom);
      c[0] = ($urandom_range(0, 15) == 0);
      apply_stimulus(c);
      check_output($sformatf("rand%0d", t), 64'(bus.out), m_out);
      gap = $urandom_range(0, 2);
      if (gap != 0) begin
        idle(gap, 8'($urandom) | 8'd1);
        check_output($sformatf("rand_idle%0d", t), 64'(bus.out), m_out);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/oscillator.md
OSCILLATOR -- requirements
Module: oscillator

Interface
REQ-001 SHALL have parameter WIDTH, default 24: width of the signed output sample.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port enable, input, 1 bit: sample tick; one high cycle equals one audio sample at 48 kHz.
REQ-005 SHALL have port cmds, input, 8 bits: command bits; bit ENVELOPE_RESET_BIT (bit 0) is envelope/phase restart, other bits ignored.
REQ-006 SHALL have port freq, input, 16 bits: note frequency in Hz, unsigned.
REQ-007 SHALL have port envelopes, input, 8 entries of {rate 16 bits, duration 24 bits}: envelope stage table.
REQ-008 SHALL have port amplitude, input, 24 bits: unsigned peak-amplitude scale.
REQ-009 SHALL have port shape, input, 2 bits: shape code SAW=0, SQUARE=1, TRIANGLE=2, SIN=3.
REQ-010 SHALL have port out, output, WIDTH bits signed: registered output sample.

Function
REQ-011 SHALL keep a 32-bit phase accumulator; step = freq*89478, truncated mod 2^32.
REQ-012 SHALL derive raw wave w (signed 16) from phase p: SAW w=p[31:16]-32768; SQUARE w=+32767 if p[31]=0 else -32767; TRIANGLE = linear fold of p[31:16] reaching -32768 at p=0 and +32767 at p=2^31; SIN w=LUT[p[31:22]], 1024 entries, round(32767*sin(2*pi*k/1024)).
REQ-013 SHALL keep envelope stage (0..7, plus DONE) and a 24-bit sample counter within the stage.
REQ-014 SHALL use gain g = envelopes[stage].rate (unsigned Q8.8, 256 = unity); g = 0 in DONE.
REQ-015 SHALL advance stage and clear counter on a tick where counter >= duration-1; duration 0 behaves as 1 sample; leaving stage 7 enters DONE, held until restart.
REQ-016 SHALL compute s1 = (w*amplitude) >>> 15 (arithmetic, floor), then s2 = (s1*g) >>> 8, then saturate to signed WIDTH range.
REQ-017 On each rising clk edge with enable=1 SHALL register out from the current (pre-update) phase/stage, then phase += step and the envelope counter/stage advances.
REQ-018 If cmds bit 0 = 1 on a tick, SHALL treat phase, stage and counter as 0 for that tick's sample, then advance from that cleared state.
REQ-019 With enable=0 SHALL hold out, phase, stage and counter unchanged; cmds ignored.
REQ-020 freq, shape, amplitude and envelopes SHALL be sampled combinationally on each tick; a change takes effect on the next tick without restart.
REQ-021 Latency: out SHALL reflect a tick's sample immediately after that tick's clock edge.

Reset
REQ-022 While rst=1, out=0, phase=0, stage=0, counter=0.
REQ-023 After rst release, the first tick SHALL produce the phase-0, stage-0 sample.

Verification
REQ-024 Reset: assert rst mid-operation -> out=0 the same cycle; release with enable=0 -> out stays 0.
REQ-025 SQUARE, freq=12000, amplitude=200, env[0]={256, 1000} -> out per tick: +199,+199,+199,-200,-200,+199,+199,-200,-200.
REQ-026 SQUARE, freq=0, amplitude=256, env[0]={256,3}, env[1]={128,2}, env[2..7]={0,1} -> out per tick: 255,255,255,127,127,0 x6, then 0 held (DONE).
REQ-027 SAW, freq=0, amplitude=256, env[0]={256,10} -> out=-256 every tick; SIN under the same stimulus -> out=0.
REQ-028 cmds bit 0 pulsed on one tick in the REQ-026 run after DONE -> that tick outputs 255 and the sequence restarts.
REQ-029 enable held low 100 cycles mid-run -> out, phase and stage frozen; the next tick continues the sequence exactly.
